// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the IF/LSU memory port arbiter
package mem_utils;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// rtl/mem_port_arbiter_lane_align.sv - byte enables, store replication, misalign flag and load lane shift
module mem_lane_align
  import mem_utils::*;
(
  input  logic [1:0]  req_off,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_shifted
);

  // Decode the store size into lane enables and replicate the data onto every lane it may hit
  always_comb begin
    be          = 4'b0000;
    wdata_rep   = req_wdata;
    misalign    = 1'b0;
    case (req_size)
      MEM_BYTE: begin
        be        = 4'b0001 << req_off;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      MEM_HALF: begin
        be        = 4'b0011 << {req_off[1], 1'b0};
        wdata_rep = {2{req_wdata[15:0]}};
        misalign  = req_off[0];
      end
      MEM_WORD: begin
        be        = 4'b1111;
        misalign  = (req_off != 2'b00);
      end
      default: begin
        misalign  = 1'b1;
      end
    endcase
  end

  // Move the addressed lane down to bit 0 so extension logic always looks at [7:0]/[15:0]
  always_comb begin
    rsp_shifted = rsp_rdata >> {rsp_off, 3'b000};
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin IF/LSU arbiter for a single-ported word memory
module mem_port_arbiter
  import mem_utils::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  arb_state_e     state;
  owner_e         owner_q;
  owner_e         last_owner;
  logic [TW-1:0]  timer;
  logic [1:0]     off_q;
  logic           we_q;
  logic           idle;
  logic           if_misalign;
  logic           lsu_misalign;
  logic [3:0]     lsu_be;
  logic [31:0]    lsu_wrep;
  logic [31:0]    lsu_shifted;

  mem_lane_align u_align (
    .req_off     (lsu_addr[1:0]),
    .req_size    (lsu_size),
    .req_wdata   (lsu_wdata),
    .be          (lsu_be),
    .wdata_rep   (lsu_wrep),
    .misalign    (lsu_misalign),
    .rsp_off     (off_q),
    .rsp_rdata   (mem_rdata),
    .rsp_shifted (lsu_shifted)
  );

  // Grants are only offered in IDLE (and never while reset is held); a tie goes to whoever was not served last
  assign idle        = rst_n && (state == ARB_IDLE);
  assign if_misalign = (if_addr[1:0] != 2'b00);
  assign if_gnt      = idle && if_req  && (!lsu_req || last_owner == OWN_LSU);
  assign lsu_gnt     = idle && lsu_req && (!if_req  || last_owner == OWN_IF);
  assign mem_req     = (state == ARB_BUSY);
  assign mem_we      = mem_req && we_q;

  // Arbiter FSM: accept a grant, hold the memory request until ack or timeout, then post a one-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      owner_q    <= OWN_IF;
      last_owner <= OWN_IF;
      timer      <= '0;
      off_q      <= 2'b00;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      lsu_rvalid <= 1'b0;
      lsu_rdata  <= '0;
      lsu_err    <= 1'b0;
    end else begin
      if_rvalid  <= 1'b0;
      if_err     <= 1'b0;
      lsu_rvalid <= 1'b0;
      lsu_err    <= 1'b0;
      case (state)
        ARB_IDLE: begin
          // Rejected requests still count as served so a misbehaving requester cannot starve the other
          if (if_gnt) begin
            last_owner <= OWN_IF;
            if (if_misalign) begin
              if_err <= 1'b1;
            end else begin
              state     <= ARB_BUSY;
              owner_q   <= OWN_IF;
              timer     <= '0;
              off_q     <= 2'b00;
              we_q      <= 1'b0;
              mem_addr  <= {if_addr[31:2], 2'b00};
              mem_be    <= 4'b1111;
              mem_wdata <= '0;
            end
          end else if (lsu_gnt) begin
            last_owner <= OWN_LSU;
            if (lsu_misalign) begin
              lsu_err <= 1'b1;
            end else begin
              state     <= ARB_BUSY;
              owner_q   <= OWN_LSU;
              timer     <= '0;
              off_q     <= lsu_addr[1:0];
              we_q      <= lsu_we;
              mem_addr  <= {lsu_addr[31:2], 2'b00};
              mem_be    <= lsu_be;
              mem_wdata <= lsu_wrep;
            end
          end
        end
        ARB_BUSY: begin
          // An ack in the final allowed cycle still wins over the timeout
          if (mem_ack) begin
            state <= ARB_IDLE;
            if (owner_q == OWN_LSU) begin
              lsu_rvalid <= 1'b1;
              lsu_rdata  <= lsu_shifted;
            end else begin
              if_rvalid  <= 1'b1;
              if_rdata   <= mem_rdata;
            end
          end else if (TIMEOUT_CYCLES != 0 && timer == TMAX) begin
            state <= ARB_IDLE;
            if (owner_q == OWN_LSU) begin
              lsu_err <= 1'b1;
            end else begin
              if_err  <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [1:0]  lsu_size = 2'b10;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
    .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          is_lsu;
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    bit          exp_err;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Responses and grants must never go to both requesters at once
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if ((if_gnt && lsu_gnt) || (if_rvalid && lsu_rvalid) || (if_err && lsu_err)) begin
        n_fail++;
        $display("FAIL exclusive: gnt %b%b rvalid %b%b err %b%b expected at most one of each",
                 if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, if_err, lsu_err);
      end
    end
  end

  // Reference: which lanes an access covers and what the LSU sees, computed from byte counts
  function automatic vec_t make_vec(input bit is_lsu, input bit we, input logic [1:0] size,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] rdata, input int waits);
    vec_t v;
    int n, off;
    logic [31:0] low;
    v.is_lsu = is_lsu; v.we = is_lsu ? we : 1'b0; v.size = size; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.waits = waits;
    off = int'(addr % 4);
    n = !is_lsu ? 4 : (size == 2'd3 ? 0 : (1 << size));
    v.exp_err = (n == 0) || (off % n != 0);
    v.exp_maddr = addr - off;
    v.exp_be = '0;
    v.exp_wdata = '0;
    if (!v.exp_err) begin
      for (int k = 0; k < n; k++) v.exp_be[off + k] = 1'b1;
      low = (n == 4) ? wdata : (wdata & ((32'd1 << (8 * n)) - 1));
      for (int k = 0; k < 4; k += n) v.exp_wdata |= low << (8 * k);
    end
    v.exp_rdata = is_lsu ? (rdata >> (8 * off)) : rdata;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    @(negedge clk);
    mem_ack = 1'b0;
    if (v.is_lsu) begin
      if_req = 1'b0; lsu_req = 1'b1; lsu_we = v.we; lsu_addr = v.addr;
      lsu_size = v.size; lsu_wdata = v.wdata;
    end else begin
      lsu_req = 1'b0; if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk({tag, " gnt"}, v.is_lsu ? lsu_gnt : if_gnt, 1);
    chk({tag, " other_gnt"}, v.is_lsu ? if_gnt : lsu_gnt, 0);
    @(posedge clk);
    @(negedge clk);
    if_req = 1'b0; lsu_req = 1'b0;
    if (v.exp_err) begin
      chk({tag, " err"}, v.is_lsu ? lsu_err : if_err, 1);
      chk({tag, " err_rvalid"}, {if_rvalid, lsu_rvalid}, 0);
      chk({tag, " err_mem_req"}, mem_req, 0);
      return;
    end
    chk({tag, " mem_req"}, mem_req, 1);
    chk({tag, " mem_we"}, mem_we, v.we);
    chk({tag, " mem_addr"}, mem_addr, v.exp_maddr);
    chk({tag, " mem_be"}, mem_be, v.exp_be);
    if (v.we) chk({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
    repeat (v.waits) begin
      @(negedge clk);
      chk({tag, " hold_req"}, mem_req, 1);
      chk({tag, " hold_addr"}, mem_addr, v.exp_maddr);
    end
    mem_ack = 1'b1;
    mem_rdata = v.rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    chk({tag, " rvalid"}, v.is_lsu ? lsu_rvalid : if_rvalid, 1);
    chk({tag, " other_rvalid"}, v.is_lsu ? if_rvalid : lsu_rvalid, 0);
    chk({tag, " rsp_err"}, {if_err, lsu_err}, 0);
    chk({tag, " rsp_mem_req"}, mem_req, 0);
    if (!v.we) chk({tag, " rdata"}, v.is_lsu ? lsu_rdata : if_rdata, v.exp_rdata);
  endtask

  vec_t tbl [11];

  initial begin
    int gcount, idx, cnt, err_at;
    bit bad_order;
    vec_t rv;

    tbl[0]  = '{1'b1, 1'b1, 2'b00, 32'h0000_0103, 32'h1234_56A5, 32'h0,          2, 1'b0, 32'h100, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0202, 32'h0,          32'h8001_1234, 1, 1'b0, 32'h200, 4'b1100, 32'h0,          32'h0000_8001};
    tbl[2]  = '{1'b1, 1'b1, 2'b10, 32'h0000_0101, 32'h1111_2222, 32'h0,          0, 1'b1, 32'h0,   4'b0000, 32'h0,          32'h0};
    tbl[3]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0102, 32'h0,          32'h0,          0, 1'b1, 32'h0,   4'b0000, 32'h0,          32'h0};
    tbl[4]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'h0,          32'hDEAD_BEEF, 0, 1'b0, 32'h40,  4'b1111, 32'h0,          32'hDEAD_BEEF};
    tbl[5]  = '{1'b1, 1'b0, 2'b11, 32'h0000_0010, 32'h0,          32'h0,          0, 1'b1, 32'h0,   4'b0000, 32'h0,          32'h0};
    tbl[6]  = '{1'b1, 1'b1, 2'b01, 32'h0000_0206, 32'hFFFF_BEEF, 32'h0,          3, 1'b0, 32'h204, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0301, 32'h0,          32'h1122_3344, 0, 1'b0, 32'h300, 4'b0010, 32'h0,          32'h0011_2233};
    tbl[8]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0400, 32'h0,          32'hCAFE_F00D, 1, 1'b0, 32'h400, 4'b1111, 32'h0,          32'hCAFE_F00D};
    tbl[9]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0203, 32'h0,          32'h0,          0, 1'b1, 32'h0,   4'b0000, 32'h0,          32'h0};
    tbl[10] = '{1'b1, 1'b1, 2'b10, 32'h0000_0080, 32'h1234_5678, 32'h0,          2, 1'b0, 32'h80,  4'b1111, 32'h1234_5678, 32'h0};

    // Reset with both requesters already asking and the memory acking every cycle
    if_req = 1'b1; if_addr = 32'h20;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h10; lsu_size = 2'b10;
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(|{if_gnt, if_rvalid, if_rdata, if_err, lsu_gnt, lsu_rvalid, lsu_rdata,
                               lsu_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata}), 0);
    rst_n = 1'b1;
    gcount = 0;
    bad_order = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (lsu_gnt || if_gnt) begin
        if ((gcount % 2 == 0) != lsu_gnt) bad_order = 1'b1;
        gcount++;
      end
      @(negedge clk);
    end
    chk("rr_grant_count", gcount, 6);
    chk("rr_alternation", bad_order, 0);
    if_req = 1'b0; lsu_req = 1'b0;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;

    for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 2) != 0) a = a & ~32'h3 | ($urandom_range(0, 1) ? 32'h2 : 32'h0);
      rv = make_vec($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                    a, $urandom, $urandom, $urandom_range(0, 3));
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    // Timeout: no ack ever, then a stray ack after the abort
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h500; lsu_size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    lsu_req = 1'b0;
    cnt = 0; err_at = -1;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) cnt++;
      if (lsu_err && err_at < 0) err_at = i;
      @(negedge clk);
    end
    chk("to_req_cycles", cnt, 4);
    chk("to_err_cycle", err_at, 4);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("to_stray_rvalid", {if_rvalid, lsu_rvalid}, 0);
    chk("to_stray_mem_req", mem_req, 0);

    // Reset in the middle of an access, then a tie right after release
    @(negedge clk);
    lsu_req = 1'b1; lsu_addr = 32'h600; lsu_size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    chk("rb_busy", mem_req, 1);
    if_req = 1'b1; if_addr = 32'h700;
    rst_n = 1'b0;
    #1;
    chk("rb_outputs", 32'(|{if_gnt, if_rvalid, if_rdata, if_err, lsu_gnt, lsu_rvalid, lsu_rdata,
                           lsu_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rb_tie_lsu", lsu_gnt, 1);
    chk("rb_tie_if", if_gnt, 0);
    if_req = 1'b0; lsu_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, word-addressed data/instruction memory between instruction fetch (IF) and the load/store unit (LSU). Arbitrates round-robin and sequences each access as a request/acknowledge transaction. Generates byte enables and replicated write data from the store size. Returns load data lane-shifted so the LSU's sign/zero extension always reads bits [7:0]/[15:0], and flags misaligned or timed-out accesses.

## Interface
- TIMEOUT_CYCLES, 255, BUSY cycles without mem_ack before the access is aborted with an error; 0 disables the timeout.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  32  fetched word
- if_err  out  1  one-cycle pulse, fetch failed (misaligned/timeout)
- lsu_req  in  1  LSU request
- lsu_we  in  1  1 = store, 0 = load
- lsu_addr  in  32  byte address
- lsu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- lsu_wdata  in  32  store data, right-aligned
- lsu_gnt  out  1  LSU request accepted this cycle
- lsu_rvalid  out  1  one-cycle pulse, access complete (also for stores)
- lsu_rdata  out  32  load word shifted right by 8*lsu_addr[1:0]
- lsu_err  out  1  one-cycle pulse, access failed
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write strobe
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated write data
- mem_ack  in  1  memory completes access this cycle; mem_rdata valid
- mem_rdata  in  32  read word

## Operation
- States: IDLE, BUSY.
- IDLE: combinational grant to at most one requester; request accepted when req && gnt at the clock edge.
- Both requesting: grant the one not served last. last_owner resets to IF, so the first tie goes to the LSU.
- Misaligned or illegal request (if_addr[1:0]≠0; LSU half with addr[0]=1; word with addr[1:0]≠0; size 11):
  - still granted; no memory access; stays IDLE.
  - err pulses next cycle; rvalid stays 0.
- Legal request: latch owner, address, we, be, wdata; go to BUSY.
- BUSY:
  - mem_req=1 with latched fields, stable until mem_ack.
  - Both gnt outputs are 0; requester inputs are ignored.
- mem_ack in BUSY:
  - Capture rdata (lane-shifted if owner is LSU); go to IDLE.
  - Owner's rvalid pulses in the next cycle; last_owner is updated.
- Timeout: timer counts BUSY cycles. At TIMEOUT_CYCLES without ack:
  - drop mem_req, go to IDLE, owner's err pulses next cycle.
  - A later stray mem_ack in IDLE is ignored.
- Byte enables and write data:
  - Byte: be=4'b0001<<a[1:0], wdata={4{wdata[7:0]}}.
  - Half: be=4'b0011<<{a[1],1'b0}, wdata={2{wdata[15:0]}}.
  - Word: be=4'b1111.
  - Loads drive the same be; IF always uses 4'b1111.
- IF rdata is unshifted. lsu_rdata = mem_rdata >> (8*a[1:0]), zero-filled.

## Timing
- Reset (async assert, sync-safe deassert):
  - All outputs 0, state IDLE, timer 0, last_owner IF.
  - An in-flight access is dropped; memory must tolerate mem_req falling mid-access.
- Request accepted at edge N → mem_req high from cycle N+1.
- mem_ack sampled at edge M → rvalid/rdata at cycle M+1, state IDLE at M+1.
- Minimum occupancy is 3 cycles per access (grant, BUSY+ack, response). A new grant may coincide with the previous response cycle.
- Zero-wait memory (mem_ack in the first BUSY cycle) is legal.
- Error response for a rejected request: err at N+1, requester may re-request at N+1.
- rvalid, err and gnt are never asserted to both requesters in the same cycle.

## Structure
- Shared package mem_utils:
  - mem_size_e (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10)
  - owner_e (OWN_IF, OWN_LSU)
  - arb_state_e (ARB_IDLE, ARB_BUSY)
- Sub-module mem_lane_align, purely combinational, computes:
  - be, wdata replication and misalign flag from (addr[1:0], size, wdata);
  - the load right-shift.
- Arbiter FSM, timer and response registers stay in mem_port_arbiter.

## Test plan
- LSU SB, addr 0x103, wdata 0xA5: mem_addr 0x100, be 4'b1000, mem_wdata 0xA5A5A5A5; ack after 2 wait cycles → lsu_rvalid one cycle after ack.
- LSU LH, addr 0x202, mem_rdata 0x8001_xxxx: lsu_rdata 0x0000_8001, be 4'b1100.
- if_req and lsu_req held high continuously from reset, immediate acks: grants alternate LSU, IF, LSU, IF; no back-to-back same owner.
- LSU SW at 0x101: lsu_gnt=1, lsu_err pulse next cycle, mem_req never rises; IF fetch at 0x102 behaves the same on if_err.
- TIMEOUT_CYCLES=4, no ack: mem_req high exactly 4 cycles, then owner's err pulses; a later stray mem_ack produces no rvalid.
- rst_n asserted in BUSY: mem_req and all outputs 0 immediately. After release, an IF/LSU tie is granted to the LSU first.
